// File: rtl/eth_mac_table_if.sv
// Request/response bus between header parse, the MAC table and the egress queues.
interface eth_mac_table_if #(
   parameter int unsigned NUM_PORTS = 4,
   parameter int unsigned MAC_W     = 48
);
   localparam int unsigned PW = $clog2(NUM_PORTS);

   logic                 req_valid;
   logic                 req_ready;
   logic [MAC_W-1:0]     req_src_mac;
   logic [MAC_W-1:0]     req_dst_mac;
   logic [PW-1:0]        req_in_port;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [NUM_PORTS-1:0] rsp_port_mask;
   logic                 rsp_hit;

   // Requester side: issues frames, consumes port masks.
   modport master (
      output req_valid, req_src_mac, req_dst_mac, req_in_port, rsp_ready,
      input  req_ready, rsp_valid, rsp_port_mask, rsp_hit
   );

   // Table side.
   modport slave (
      input  req_valid, req_src_mac, req_dst_mac, req_in_port, rsp_ready,
      output req_ready, rsp_valid, rsp_port_mask, rsp_hit
   );
endinterface

// File: rtl/eth_mac_table.sv
// Fully associative MAC learning/forwarding table with ageing, age-based
// replacement and flush. One request in flight: IDLE->LOOKUP->UPDATE->RESP.
module eth_mac_table #(
   parameter int unsigned NUM_PORTS = 4,
   parameter int unsigned MAC_W     = 48,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned AGE_W     = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   eth_mac_table_if.slave               bus,
   input  logic                         age_tick,
   input  logic                         flush,
   output logic [$clog2(DEPTH+1)-1:0]   entries_used
);
   localparam int unsigned PW      = $clog2(NUM_PORTS);
   localparam int unsigned IW      = $clog2(DEPTH);
   localparam int unsigned CW      = $clog2(DEPTH+1);
   localparam int unsigned GRP_BIT = 40;
   localparam logic [AGE_W-1:0] AGE_MAX = '1;

   typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, RESP} state_t;

   state_t state, state_nx;

   // Captured request
   logic [MAC_W-1:0]     src_q, dst_q;
   logic [PW-1:0]        in_port_q;

   // Table storage
   logic [DEPTH-1:0]     ent_valid, valid_nx;
   logic [AGE_W-1:0]     ent_age  [DEPTH];
   logic [AGE_W-1:0]     age_nx   [DEPTH];
   logic [MAC_W-1:0]     ent_mac  [DEPTH];
   logic [PW-1:0]        ent_port [DEPTH];

   // Lookup results
   logic                 src_hit_c, dst_hit_c;
   logic [IW-1:0]        src_idx_c, dst_idx_c;
   logic                 src_hit_q, dst_hit_q;
   logic [IW-1:0]        src_idx_q;
   logic [PW-1:0]        dst_port_q;

   // Learn/forward decisions
   logic                 free_any_c;
   logic [IW-1:0]        free_idx_c, victim_idx_c, wr_idx_c;
   logic [AGE_W-1:0]     min_age_c;
   logic                 wr_en_c;
   logic [NUM_PORTS-1:0] fwd_mask_c;
   logic                 fwd_hit_c;
   logic [CW-1:0]        used_c;

   // Registered outputs
   logic                 req_ready_q, rsp_valid_q, rsp_hit_q;
   logic [NUM_PORTS-1:0] rsp_mask_q;

   assign bus.req_ready     = req_ready_q;
   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_port_mask = rsp_mask_q;
   assign bus.rsp_hit       = rsp_hit_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.req_valid) state_nx = LOOKUP;
         LOOKUP:  state_nx = UPDATE;
         UPDATE:  state_nx = RESP;
         RESP:    if (bus.rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Capture request fields on acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_q     <= '0;
         dst_q     <= '0;
         in_port_q <= '0;
      end else if (state == IDLE && bus.req_valid) begin
         src_q     <= bus.req_src_mac;
         dst_q     <= bus.req_dst_mac;
         in_port_q <= bus.req_in_port;
      end
   end

   // Parallel CAM compare; lowest matching index wins
   always_comb begin
      src_hit_c = 1'b0;
      dst_hit_c = 1'b0;
      src_idx_c = '0;
      dst_idx_c = '0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         if (ent_valid[i] && ent_mac[i] == src_q) begin
            src_hit_c = 1'b1;
            src_idx_c = IW'(i);
         end
         if (ent_valid[i] && ent_mac[i] == dst_q) begin
            dst_hit_c = 1'b1;
            dst_idx_c = IW'(i);
         end
      end
   end

   // Register lookup results (pre-learn view of the table)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_hit_q  <= 1'b0;
         dst_hit_q  <= 1'b0;
         src_idx_q  <= '0;
         dst_port_q <= '0;
      end else if (state == LOOKUP) begin
         src_hit_q  <= src_hit_c;
         dst_hit_q  <= dst_hit_c;
         src_idx_q  <= src_idx_c;
         dst_port_q <= ent_port[dst_idx_c];
      end
   end

   // Lowest free slot and oldest (smallest age, lowest index) victim
   always_comb begin
      free_any_c   = 1'b0;
      free_idx_c   = '0;
      victim_idx_c = '0;
      min_age_c    = ent_age[0];
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         if (!ent_valid[i]) begin
            free_any_c = 1'b1;
            free_idx_c = IW'(i);
         end
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
         if (ent_age[i] < min_age_c) begin
            min_age_c    = ent_age[i];
            victim_idx_c = IW'(i);
         end
      end
   end

   // Learn target: group source addresses are never learned
   always_comb begin
      wr_en_c  = (state == UPDATE) && !src_q[GRP_BIT];
      wr_idx_c = src_hit_q ? src_idx_q : (free_any_c ? free_idx_c : victim_idx_c);
   end

   // Forward decision: flood on group/miss, filter when destination is on ingress port
   always_comb begin
      fwd_mask_c = ~(NUM_PORTS'(1) << in_port_q);
      fwd_hit_c  = 1'b0;
      if (!dst_q[GRP_BIT] && dst_hit_q) begin
         fwd_hit_c  = 1'b1;
         fwd_mask_c = (dst_port_q == in_port_q) ? '0 : (NUM_PORTS'(1) << dst_port_q);
      end
   end

   // Next valid/age: flush clears first, tick ages the rest, learn write wins
   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         valid_nx[i] = ent_valid[i];
         age_nx[i]   = ent_age[i];
         if (flush) begin
            valid_nx[i] = 1'b0;
         end else if (age_tick && ent_valid[i]) begin
            if (ent_age[i] <= AGE_W'(1)) valid_nx[i] = 1'b0;
            age_nx[i] = ent_age[i] - AGE_W'(1);
         end
         if (wr_en_c && wr_idx_c == IW'(i)) begin
            valid_nx[i] = 1'b1;
            age_nx[i]   = AGE_MAX;
         end
      end
   end

   // Valid and age registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_valid <= '0;
         for (int i = 0; i < int'(DEPTH); i++) ent_age[i] <= '0;
      end else begin
         ent_valid <= valid_nx;
         for (int i = 0; i < int'(DEPTH); i++) ent_age[i] <= age_nx[i];
      end
   end

   // MAC and port storage, written on learn
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            ent_mac[i]  <= '0;
            ent_port[i] <= '0;
         end
      end else if (wr_en_c) begin
         ent_mac[wr_idx_c]  <= src_q;
         ent_port[wr_idx_c] <= in_port_q;
      end
   end

   // Population count of valid entries
   always_comb begin
      used_c = '0;
      for (int i = 0; i < int'(DEPTH); i++) used_c = used_c + CW'(ent_valid[i]);
   end

   // Occupancy output, one cycle behind the valid bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) entries_used <= '0;
      else        entries_used <= used_c;
   end

   // Handshake and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_mask_q  <= '0;
         rsp_hit_q   <= 1'b0;
      end else begin
         req_ready_q <= (state_nx == IDLE);
         rsp_valid_q <= (state_nx == RESP);
         if (state == UPDATE) begin
            rsp_mask_q <= fwd_mask_c;
            rsp_hit_q  <= fwd_hit_c;
         end
      end
   end
endmodule

// File: tb/tb_eth_mac_table.sv
// Randomized and directed bench for eth_mac_table against a table-level model.
module tb_eth_mac_table;
   localparam int DEPTH = 16;
   localparam int AMAX  = 15;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       age_tick;
   logic       flush;
   logic [4:0] entries_used;

   eth_mac_table_if #(.NUM_PORTS(4), .MAC_W(48)) bus ();

   eth_mac_table #(.NUM_PORTS(4), .MAC_W(48), .DEPTH(16), .AGE_W(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .age_tick     (age_tick),
      .flush        (flush),
      .entries_used (entries_used)
   );

   always #5 clk = ~clk;

   // Reference table
   bit          m_valid [DEPTH];
   logic [47:0] m_mac   [DEPTH];
   int          m_port  [DEPTH];
   int          m_age   [DEPTH];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic int m_find(input logic [47:0] mac);
      for (int i = 0; i < DEPTH; i++)
         if (m_valid[i] && m_mac[i] == mac) return i;
      return -1;
   endfunction

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < DEPTH; i++) c += int'(m_valid[i]);
      return c;
   endfunction

   task automatic m_tick();
      for (int i = 0; i < DEPTH; i++)
         if (m_valid[i]) begin
            m_age[i]--;
            if (m_age[i] == 0) m_valid[i] = 1'b0;
         end
   endtask

   task automatic m_clear();
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
   endtask

   // Index the model would write for a learned source (after any flush)
   function automatic int m_learn_slot(input int hit_idx);
      int best;
      if (hit_idx >= 0) return hit_idx;
      for (int i = 0; i < DEPTH; i++) if (!m_valid[i]) return i;
      best = 0;
      for (int i = 1; i < DEPTH; i++) if (m_age[i] < m_age[best]) best = i;
      return best;
   endfunction

   // One full transaction with optional response back-pressure and side events
   task automatic run_req(input logic [47:0] src, input logic [47:0] dst, input int pin,
                          input int hold, input bit tick_upd, input bit flush_lk,
                          output logic [3:0] o_mask, output logic o_hit);
      int d_idx, s_idx, w;
      logic [3:0] e_mask;
      logic       e_hit;
      logic [3:0] in_bit;
      in_bit = 4'b0001 << pin;
      d_idx  = m_find(dst);
      s_idx  = m_find(src);
      if (dst[40] || d_idx < 0) begin
         e_mask = ~in_bit;
         e_hit  = 1'b0;
      end else begin
         e_hit  = 1'b1;
         e_mask = (m_port[d_idx] == pin) ? 4'b0000 : (4'b0001 << m_port[d_idx]);
      end

      @(negedge clk);
      check("req_ready_idle", bus.req_ready, 1);
      bus.req_valid   = 1'b1;
      bus.req_src_mac = src;
      bus.req_dst_mac = dst;
      bus.req_in_port = 2'(pin);
      bus.rsp_ready   = (hold == 0);
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("req_ready_busy", bus.req_ready, 0);
      check("rsp_valid_early", bus.rsp_valid, 0);
      if (flush_lk) flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      if (tick_upd) age_tick = 1'b1;
      @(negedge clk);
      age_tick = 1'b0;

      if (flush_lk) m_clear();
      w = src[40] ? -1 : m_learn_slot(s_idx);
      if (tick_upd) m_tick();
      if (w >= 0) begin
         m_valid[w] = 1'b1;
         m_mac[w]   = src;
         m_port[w]  = pin;
         m_age[w]   = AMAX;
      end

      check("rsp_valid", bus.rsp_valid, 1);
      check("rsp_mask", bus.rsp_port_mask, e_mask);
      check("rsp_hit", bus.rsp_hit, e_hit);
      o_mask = bus.rsp_port_mask;
      o_hit  = bus.rsp_hit;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_valid", bus.rsp_valid, 1);
         check("hold_mask", bus.rsp_port_mask, e_mask);
         check("hold_ready", bus.req_ready, 0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("rsp_valid_drop", bus.rsp_valid, 0);
      check("req_ready_back", bus.req_ready, 1);
      check("entries_used", entries_used, m_count());
   endtask

   task automatic do_tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         age_tick = 1'b1;
         @(negedge clk);
         age_tick = 1'b0;
         m_tick();
      end
      @(negedge clk);
      check("used_after_tick", entries_used, m_count());
   endtask

   task automatic do_flush();
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      m_clear();
      @(negedge clk);
      check("used_after_flush", entries_used, 0);
   endtask

   localparam logic [47:0] MAC_A = 48'h0200_0000_000A;
   localparam logic [47:0] MAC_B = 48'h0200_0000_000B;
   localparam logic [47:0] MAC_C = 48'h0200_0000_000C;
   localparam logic [47:0] MAC_D = 48'h0200_0000_000D;
   localparam logic [47:0] MAC_E = 48'h0200_0000_000E;
   localparam logic [47:0] MAC_N = 48'h0200_0000_00EE;
   localparam logic [47:0] GRP   = 48'h0300_0000_0099;
   localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

   logic [3:0]  mk;
   logic        ht;
   logic [47:0] pool [24];
   int          seen;

   initial begin
      rst_n = 1'b0;
      age_tick = 1'b0;
      flush = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_src_mac = '0;
      bus.req_dst_mac = '0;
      bus.req_in_port = '0;
      bus.rsp_ready = 1'b1;
      m_clear();
      repeat (3) @(negedge clk);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_mask", bus.rsp_port_mask, 0);
      check("rst_rsp_hit", bus.rsp_hit, 0);
      check("rst_entries_used", entries_used, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_req_ready", bus.req_ready, 1);

      // Basic learn, forward, filter, broadcast, group source
      run_req(MAC_A, MAC_B, 1, 0, 0, 0, mk, ht);
      check("t1_mask", mk, 4'b1101);
      check("t1_hit", ht, 0);
      check("t1_used", entries_used, 1);
      run_req(MAC_B, MAC_A, 2, 0, 0, 0, mk, ht);
      check("t2_mask", mk, 4'b0010);
      check("t2_hit", ht, 1);
      run_req(MAC_C, MAC_A, 1, 0, 0, 0, mk, ht);
      check("t2_filter_mask", mk, 4'b0000);
      check("t2_filter_hit", ht, 1);
      run_req(MAC_C, BCAST, 0, 0, 0, 0, mk, ht);
      check("t3_bcast_mask", mk, 4'b1110);
      check("t3_bcast_hit", ht, 0);
      run_req(GRP, MAC_A, 3, 0, 0, 0, mk, ht);
      check("t3_grp_used", entries_used, 3);

      // Fill table, leave entry 3 oldest, learn one more
      do_flush();
      for (int i = 0; i < 4; i++) run_req(48'h0200_0000_0100 + 48'(i), BCAST, i % 4, 0, 0, 0, mk, ht);
      do_tick(2);
      for (int i = 4; i < 16; i++) run_req(48'h0200_0000_0100 + 48'(i), BCAST, i % 4, 0, 0, 0, mk, ht);
      for (int i = 0; i < 3; i++) run_req(48'h0200_0000_0100 + 48'(i), BCAST, i % 4, 0, 0, 0, mk, ht);
      check("t4_full", entries_used, 16);
      run_req(MAC_N, BCAST, 2, 0, 0, 0, mk, ht);
      run_req(GRP, 48'h0200_0000_0103, 0, 0, 0, 0, mk, ht);
      check("t4_evicted_hit", ht, 0);
      run_req(GRP, 48'h0200_0000_0104, 1, 0, 0, 0, mk, ht);
      check("t4_kept_hit", ht, 1);
      run_req(GRP, MAC_N, 0, 0, 0, 0, mk, ht);
      check("t4_new_mask", mk, 4'b0100);

      // Ageing out, and tick coinciding with a learn
      do_flush();
      run_req(MAC_A, BCAST, 1, 0, 0, 0, mk, ht);
      do_tick(14);
      run_req(GRP, MAC_A, 0, 0, 0, 0, mk, ht);
      check("t5_alive_hit", ht, 1);
      do_tick(1);
      check("t5_aged_used", entries_used, 0);
      run_req(GRP, MAC_A, 0, 0, 0, 0, mk, ht);
      check("t5_aged_mask", mk, 4'b1110);
      run_req(MAC_E, BCAST, 3, 0, 0, 0, mk, ht);
      run_req(MAC_D, BCAST, 2, 0, 1, 0, mk, ht);
      do_tick(14);
      check("t5_tick_learn_used", entries_used, 1);
      run_req(GRP, MAC_D, 0, 0, 0, 0, mk, ht);
      check("t5_tick_learn_hit", ht, 1);

      // Back-pressure and flush during lookup
      run_req(MAC_B, BCAST, 2, 10, 0, 0, mk, ht);
      run_req(MAC_C, MAC_B, 1, 0, 0, 1, mk, ht);
      check("t6_flush_hit", ht, 1);
      check("t6_flush_used", entries_used, 1);
      run_req(GRP, MAC_C, 0, 0, 0, 1, mk, ht);
      check("t6_flush_grp_used", entries_used, 0);

      // Reset in the middle of a request drops it
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_src_mac = MAC_A;
      bus.req_dst_mac = MAC_B;
      bus.req_in_port = 2'd1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_clear();
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.rsp_valid) seen++;
      end
      check("midreset_no_rsp", seen, 0);
      check("midreset_used", entries_used, 0);

      // Randomized traffic
      for (int i = 0; i < 24; i++)
         pool[i] = {((i % 7) == 0) ? 8'h03 : 8'h02, 32'h0, 8'(i)};
      for (int n = 0; n < 250; n++) begin
         logic [47:0] s, d;
         s = pool[$urandom_range(23, 0)];
         d = ($urandom_range(9, 0) == 0) ? BCAST : pool[$urandom_range(23, 0)];
         run_req(s, d, int'($urandom_range(3, 0)), int'($urandom_range(2, 0)),
                 ($urandom_range(7, 0) == 0), ($urandom_range(40, 0) == 0), mk, ht);
         if ($urandom_range(5, 0) == 0) do_tick(int'($urandom_range(3, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
